// File: rtl/tc0360pri_pkg.sv
// Shared definitions for the tc0360pri priority mixer: register indices,
// source identifiers and the priority type.
package tc0360pri_pkg;

  localparam logic [3:0] PRI_AB    = 4'd4;
  localparam logic [3:0] PRI_C     = 4'd5;
  localparam logic [3:0] PRI_OBJ01 = 4'd6;
  localparam logic [3:0] PRI_OBJ23 = 4'd7;

  typedef enum logic [1:0] {SRC_A, SRC_B, SRC_C, SRC_OBJ} src_t;

  typedef logic [3:0] prio_t;

  // A transparent pen (0) never competes, whatever its programmed priority.
  function automatic prio_t eff_prio(input logic [3:0] pen, input prio_t pri);
    return (pen == 4'd0) ? 4'd0 : pri;
  endfunction

endpackage

// File: rtl/tc0360pri_regs.sv
// CPU-side register file for tc0360pri: CSn falling-edge detect, 16 x 8-bit
// registers, registered read data and the active-low data acknowledge.
module tc0360pri_regs
  import tc0360pri_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  input  logic [3:0] i_va,
  input  logic       i_rwn,
  input  logic       i_csn,
  output logic       o_dackn,
  output prio_t      o_pri_a,
  output prio_t      o_pri_b,
  output prio_t      o_pri_c,
  output prio_t      o_pri_obj0,
  output prio_t      o_pri_obj1,
  output prio_t      o_pri_obj2,
  output prio_t      o_pri_obj3
);

  logic [7:0] r_regs [16];
  logic       r_csn_prev;
  logic       r_armed;
  logic [7:0] r_dout;
  logic       r_dackn;
  logic       w_start;

  // r_armed blocks a CSn that is still low when reset releases from being
  // taken as a fresh access; CSn must first be seen high.
  assign w_start = r_armed & r_csn_prev & ~i_csn;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_csn_prev <= 1'b1;
      r_armed    <= 1'b0;
      r_dout     <= '0;
      r_dackn    <= 1'b1;
    end else begin
      r_csn_prev <= i_csn;
      if (i_csn) r_armed <= 1'b1;
      if (w_start) begin
        if (!i_rwn) r_regs[i_va] <= i_din;
        else        r_dout       <= r_regs[i_va];
        r_dackn <= 1'b0;
      end else if (i_csn) begin
        r_dackn <= 1'b1;
      end
    end
  end

  assign o_dout     = r_dout;
  assign o_dackn    = r_dackn;
  assign o_pri_a    = r_regs[PRI_AB][3:0];
  assign o_pri_b    = r_regs[PRI_AB][7:4];
  assign o_pri_c    = r_regs[PRI_C][3:0];
  assign o_pri_obj0 = r_regs[PRI_OBJ01][3:0];
  assign o_pri_obj1 = r_regs[PRI_OBJ01][7:4];
  assign o_pri_obj2 = r_regs[PRI_OBJ23][3:0];
  assign o_pri_obj3 = r_regs[PRI_OBJ23][7:4];

endmodule

// File: rtl/tc0360pri.sv
// Priority mixer: resolves three tilemap layers and one sprite source into a
// 15-bit palette index through a 2-stage ce_pixel pipeline.
module tc0360pri
  import tc0360pri_pkg::*;
#(
  parameter int PIPE_SYNC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pixel,
  input  logic [7:0]  Din,
  output logic [7:0]  Dout,
  input  logic [3:0]  VA,
  input  logic        RWn,
  input  logic        CSn,
  output logic        DACKn,
  input  logic [14:0] LA,
  input  logic [14:0] LB,
  input  logic [14:0] LC,
  input  logic [13:0] OBJ,
  input  logic        HSYn_in,
  input  logic        VSYn_in,
  output logic        HSYn,
  output logic        VSYn,
  output logic [14:0] SC
);

  prio_t       w_pri_a, w_pri_b, w_pri_c;
  prio_t       w_pri_obj0, w_pri_obj1, w_pri_obj2, w_pri_obj3;
  prio_t       w_obj_pri;
  prio_t       w_best_pri;
  logic [14:0] w_best_col;
  logic        w_unused_msb;

  prio_t       r_s1_pri [4];
  logic [14:0] r_s1_col [4];
  logic [14:0] r_sc;

  tc0360pri_regs u_regs (
    .clk        (clk),
    .reset      (reset),
    .i_din      (Din),
    .o_dout     (Dout),
    .i_va       (VA),
    .i_rwn      (RWn),
    .i_csn      (CSn),
    .o_dackn    (DACKn),
    .o_pri_a    (w_pri_a),
    .o_pri_b    (w_pri_b),
    .o_pri_c    (w_pri_c),
    .o_pri_obj0 (w_pri_obj0),
    .o_pri_obj1 (w_pri_obj1),
    .o_pri_obj2 (w_pri_obj2),
    .o_pri_obj3 (w_pri_obj3)
  );

  // Layer bit 14 never reaches SC.
  assign w_unused_msb = LA[14] ^ LB[14] ^ LC[14];

  always_comb begin
    w_obj_pri = w_pri_obj0;
    case (OBJ[13:12])
      2'd0: w_obj_pri = w_pri_obj0;
      2'd1: w_obj_pri = w_pri_obj1;
      2'd2: w_obj_pri = w_pri_obj2;
      2'd3: w_obj_pri = w_pri_obj3;
      default: w_obj_pri = w_pri_obj0;
    endcase
  end

  // Stage 1: colour and effective priority per source.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_s1_pri[i] <= '0;
        r_s1_col[i] <= '0;
      end
    end else if (ce_pixel) begin
      r_s1_pri[int'(SRC_A)]   <= eff_prio(LA[3:0], w_pri_a);
      r_s1_pri[int'(SRC_B)]   <= eff_prio(LB[3:0], w_pri_b);
      r_s1_pri[int'(SRC_C)]   <= eff_prio(LC[3:0], w_pri_c);
      r_s1_pri[int'(SRC_OBJ)] <= eff_prio(OBJ[3:0], w_obj_pri);
      r_s1_col[int'(SRC_A)]   <= {1'b0, LA[13:0]};
      r_s1_col[int'(SRC_B)]   <= {1'b0, LB[13:0]};
      r_s1_col[int'(SRC_C)]   <= {1'b0, LC[13:0]};
      r_s1_col[int'(SRC_OBJ)] <= {3'b000, OBJ[11:0]};
    end
  end

  // Scanning A..OBJ with >= lets later sources win ties (OBJ > C > B > A);
  // with nothing opaque and prioritised, layer A falls through as background.
  always_comb begin
    w_best_pri = '0;
    w_best_col = r_s1_col[int'(SRC_A)];
    for (int i = 0; i < 4; i++) begin
      if (r_s1_pri[i] != '0 && r_s1_pri[i] >= w_best_pri) begin
        w_best_pri = r_s1_pri[i];
        w_best_col = r_s1_col[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         r_sc <= '0;
    else if (ce_pixel) r_sc <= w_best_col;
  end

  assign SC = r_sc;

  generate
    if (PIPE_SYNC != 0) begin : g_sync_pipe
      logic [1:0] r_hs;
      logic [1:0] r_vs;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_hs <= 2'b11;
          r_vs <= 2'b11;
        end else if (ce_pixel) begin
          r_hs <= {r_hs[0], HSYn_in};
          r_vs <= {r_vs[0], VSYn_in};
        end
      end
      assign HSYn = r_hs[1];
      assign VSYn = r_vs[1];
    end else begin : g_sync_pass
      assign HSYn = HSYn_in;
      assign VSYn = VSYn_in;
    end
  endgenerate

endmodule
